flopoco_to_ieee_conv: RTL and testbench

- Pipelined converter on the FALU writeback side. It takes 66-bit FloPoCo-format results (2 exception bits + sign + exp + frac), the form the FP datapath units produce, and converts them to IEEE-754 binary64/binary32 register-file format.
- It NaN-boxes single-precision results, canonicalises NaNs and produces fflags contributions.
- It sits between the FALU result mux and the FP writeback/ROB path, with valid/ready handshakes on both sides.

---
 rtl/fp_conv_pkg.sv | 42 ++++
 rtl/fp_denorm_round.sv | 39 +++
 rtl/flopoco_to_ieee_conv.sv | 184 ++++++++++++++++++
 tb/tb_flopoco_to_ieee_conv.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_conv_pkg.sv
// Shared constants and types for the FloPoCo -> IEEE-754 writeback converter.
package fp_conv_pkg;

    localparam int DP_EXP_W  = 11;
    localparam int DP_FRAC_W = 52;
    localparam int SP_EXP_W  = 8;
    localparam int SP_FRAC_W = 23;

    typedef enum logic [1:0] {
        EXC_ZERO = 2'b00,
        EXC_NORM = 2'b01,
        EXC_INF  = 2'b10,
        EXC_NAN  = 2'b11
    } exc_e;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam logic [63:0] CNAN_DP = 64'h7FF8_0000_0000_0000;
    localparam logic [31:0] CNAN_SP = 32'h7FC0_0000;
    localparam logic [31:0] NANBOX  = 32'hFFFF_FFFF;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // SP fields live in the low bits of exp/frac with the upper bits zeroed.
    typedef struct packed {
        exc_e                   exc;
        logic                   sign;
        logic [DP_EXP_W-1:0]    exp;
        logic [DP_FRAC_W-1:0]   frac;
        logic [2:0]             rm;
        logic                   isdouble;
    } s1_t;

endpackage

// File: rtl/fp_denorm_round.sv
// One-bit denormalise-and-round for values just below the IEEE normal range.
module fp_denorm_round
    import fp_conv_pkg::*;
#(
    parameter int FRAC_W = 52
) (
    input  logic [FRAC_W-1:0] i_m,
    input  logic              i_d,
    input  logic              i_sign,
    input  logic [2:0]        i_rm,
    output logic              o_exp_lsb,
    output logic [FRAC_W-1:0] o_frac,
    output logic              o_nx,
    output logic              o_uf
);

    logic              w_inc;
    logic [FRAC_W:0]   w_sum;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_inc = 1'b0;
        case (i_rm)
            RM_RNE:  w_inc = i_d & i_m[0];
            RM_RTZ:  w_inc = 1'b0;
            RM_RDN:  w_inc = i_d & i_sign;
            RM_RUP:  w_inc = i_d & ~i_sign;
            RM_RMM:  w_inc = i_d;
            default: w_inc = i_d & i_m[0];
        endcase
    end

    // A carry out of the fraction lands in the exponent LSB: the minimum normal.
    assign w_sum                = {1'b0, i_m} + {{FRAC_W{1'b0}}, w_inc};
    assign {o_exp_lsb, o_frac}  = w_sum;
    assign o_nx                 = i_d;
    assign o_uf                 = i_d & ~w_sum[FRAC_W];

endmodule

// File: rtl/flopoco_to_ieee_conv.sv
// Two-stage FloPoCo -> IEEE-754 converter with NaN-boxing, NaN canonicalisation
// and fflags generation, on a valid/ready pipeline with flush.
module flopoco_to_ieee_conv
    import fp_conv_pkg::*;
#(
    parameter int TAG_W = 6
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [65:0]      IN_DATA,
    input  logic             IN_ISDOUBLE,
    input  logic [2:0]       IN_RM,
    input  logic [TAG_W-1:0] IN_TAG,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [63:0]      OUT_DATA,
    output logic [TAG_W-1:0] OUT_TAG,
    output logic [4:0]       OUT_FLAGS
);

    logic             r_s1_valid;
    s1_t              r_s1;
    logic [TAG_W-1:0] r_s1_tag;
    logic             r_s2_valid;
    logic [63:0]      r_out_data;
    logic [TAG_W-1:0] r_out_tag;
    logic [4:0]       r_out_flags;

    logic             w_adv1;
    logic             w_adv2;
    s1_t              w_s1_next;

    assign w_adv2   = ~r_s2_valid | OUT_READY;
    assign w_adv1   = ~r_s1_valid | w_adv2;
    assign IN_READY = w_adv1 & RST_N;

    always_comb begin
        w_s1_next          = '0;
        w_s1_next.rm       = IN_RM;
        w_s1_next.isdouble = IN_ISDOUBLE;
        if (IN_ISDOUBLE) begin
            w_s1_next.exc  = exc_e'(IN_DATA[65:64]);
            w_s1_next.sign = IN_DATA[63];
            w_s1_next.exp  = IN_DATA[62:52];
            w_s1_next.frac = IN_DATA[51:0];
        end else begin
            w_s1_next.exc  = exc_e'(IN_DATA[33:32]);
            w_s1_next.sign = IN_DATA[31];
            w_s1_next.exp  = {3'b000, IN_DATA[30:23]};
            w_s1_next.frac = {29'd0, IN_DATA[22:0]};
        end
    end

    logic                 w_dp_exp_lsb;
    logic [DP_FRAC_W-1:0] w_dp_frac;
    logic                 w_dp_nx;
    logic                 w_dp_uf;
    logic                 w_sp_exp_lsb;
    logic [SP_FRAC_W-1:0] w_sp_frac;
    logic                 w_sp_nx;
    logic                 w_sp_uf;

    fp_denorm_round #(.FRAC_W(DP_FRAC_W)) u_dp_round (
        .i_m       ({1'b1, r_s1.frac[DP_FRAC_W-1:1]}),
        .i_d       (r_s1.frac[0]),
        .i_sign    (r_s1.sign),
        .i_rm      (r_s1.rm),
        .o_exp_lsb (w_dp_exp_lsb),
        .o_frac    (w_dp_frac),
        .o_nx      (w_dp_nx),
        .o_uf      (w_dp_uf)
    );

    fp_denorm_round #(.FRAC_W(SP_FRAC_W)) u_sp_round (
        .i_m       ({1'b1, r_s1.frac[SP_FRAC_W-1:1]}),
        .i_d       (r_s1.frac[0]),
        .i_sign    (r_s1.sign),
        .i_rm      (r_s1.rm),
        .o_exp_lsb (w_sp_exp_lsb),
        .o_frac    (w_sp_frac),
        .o_nx      (w_sp_nx),
        .o_uf      (w_sp_uf)
    );

    logic [63:0] w_dp;
    logic [31:0] w_sp;
    logic [63:0] w_data;
    logic [4:0]  w_flags;
    logic        w_nv;
    logic        w_nx;
    logic        w_uf;

    always_comb begin
        w_dp = '0;
        w_sp = '0;
        w_nv = 1'b0;
        w_nx = 1'b0;
        w_uf = 1'b0;
        case (r_s1.exc)
            EXC_ZERO: begin
                w_dp = {r_s1.sign, 63'd0};
                w_sp = {r_s1.sign, 31'd0};
            end
            EXC_INF: begin
                w_dp = {r_s1.sign, {DP_EXP_W{1'b1}}, {DP_FRAC_W{1'b0}}};
                w_sp = {r_s1.sign, {SP_EXP_W{1'b1}}, {SP_FRAC_W{1'b0}}};
            end
            EXC_NAN: begin
                w_dp = CNAN_DP;
                w_sp = CNAN_SP;
                w_nv = r_s1.isdouble ? ~r_s1.frac[DP_FRAC_W-1] : ~r_s1.frac[SP_FRAC_W-1];
            end
            default: begin
                if (r_s1.exp != '0)
                    w_dp = {r_s1.sign, r_s1.exp, r_s1.frac};
                else
                    w_dp = {r_s1.sign, {(DP_EXP_W-1){1'b0}}, w_dp_exp_lsb, w_dp_frac};
                if (r_s1.exp[SP_EXP_W-1:0] != '0)
                    w_sp = {r_s1.sign, r_s1.exp[SP_EXP_W-1:0], r_s1.frac[SP_FRAC_W-1:0]};
                else
                    w_sp = {r_s1.sign, {(SP_EXP_W-1){1'b0}}, w_sp_exp_lsb, w_sp_frac};
                // Only the subnormal-range path can be inexact.
                if (r_s1.isdouble && r_s1.exp == '0) begin
                    w_nx = w_dp_nx;
                    w_uf = w_dp_uf;
                end else if (!r_s1.isdouble && r_s1.exp[SP_EXP_W-1:0] == '0) begin
                    w_nx = w_sp_nx;
                    w_uf = w_sp_uf;
                end
            end
        endcase
        w_data           = r_s1.isdouble ? w_dp : {NANBOX, w_sp};
        w_flags          = '0;
        w_flags[FLAG_NV] = w_nv;
        w_flags[FLAG_DZ] = 1'b0;
        w_flags[FLAG_OF] = 1'b0;
        w_flags[FLAG_UF] = w_uf;
        w_flags[FLAG_NX] = w_nx;
    end

    // NOTE: sequential state uses non-blocking assignments so all stages shift on the same edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else if (FLUSH) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_adv1) r_s1_valid <= IN_VALID;
            if (w_adv2) r_s2_valid <= r_s1_valid;
        end
    end

    // NOTE: payload registers are reset as well, so outputs read zero in reset and no X reaches them.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s1        <= '0;
            r_s1_tag    <= '0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
            r_out_flags <= '0;
        end else begin
            if (w_adv1 && IN_VALID) begin
                r_s1     <= w_s1_next;
                r_s1_tag <= IN_TAG;
            end
            if (w_adv2 && r_s1_valid) begin
                r_out_data  <= w_data;
                r_out_tag   <= r_s1_tag;
                r_out_flags <= w_flags;
            end
        end
    end

    assign OUT_VALID = r_s2_valid;
    assign OUT_DATA  = r_out_data;
    assign OUT_TAG   = r_out_tag;
    assign OUT_FLAGS = r_out_flags;

endmodule

// File: tb/tb_flopoco_to_ieee_conv.sv
// Randomised + directed bench for flopoco_to_ieee_conv, scored against an arithmetic model.
module tb_flopoco_to_ieee_conv;

    localparam int TAG_W = 6;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             FLUSH;
    logic             IN_VALID;
    logic             IN_READY;
    logic [65:0]      IN_DATA;
    logic             IN_ISDOUBLE;
    logic [2:0]       IN_RM;
    logic [TAG_W-1:0] IN_TAG;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [63:0]      OUT_DATA;
    logic [TAG_W-1:0] OUT_TAG;
    logic [4:0]       OUT_FLAGS;

    flopoco_to_ieee_conv #(.TAG_W(TAG_W)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .FLUSH       (FLUSH),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .IN_DATA     (IN_DATA),
        .IN_ISDOUBLE (IN_ISDOUBLE),
        .IN_RM       (IN_RM),
        .IN_TAG      (IN_TAG),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .OUT_DATA    (OUT_DATA),
        .OUT_TAG     (OUT_TAG),
        .OUT_FLAGS   (OUT_FLAGS)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    int n_out = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [63:0]      data;
        logic [4:0]       flags;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t q[$];

    // Reference: decode fields, then build the IEEE word with plain shifts and adds.
    function automatic exp_t model(logic [65:0] d, logic dbl, logic [2:0] rm, logic [TAG_W-1:0] t);
        int          fw, ew;
        logic [1:0]  exc;
        logic        s, db, lsb, inc, nv, nx, uf;
        logic [63:0] e, f, r, m, v;
        exp_t        res;
        fw = dbl ? 52 : 23;
        ew = dbl ? 11 : 8;
        if (dbl) begin
            exc = d[65:64]; s = d[63]; e = 64'(d[62:52]); f = 64'(d[51:0]);
        end else begin
            exc = d[33:32]; s = d[31]; e = 64'(d[30:23]); f = 64'(d[22:0]);
        end
        nv = 1'b0; nx = 1'b0; uf = 1'b0;
        case (exc)
            2'b00: r = 64'(s) << (fw + ew);
            2'b10: r = (64'(s) << (fw + ew)) | (((64'd1 << ew) - 64'd1) << fw);
            2'b11: begin
                r  = dbl ? 64'h7FF8_0000_0000_0000 : 64'h0000_0000_7FC0_0000;
                nv = ~f[fw-1];
            end
            default: begin
                if (e != 0) begin
                    r = (64'(s) << (fw + ew)) | (e << fw) | f;
                end else begin
                    m   = ((64'd1 << fw) | f) >> 1;
                    db  = f[0];
                    lsb = f[1];
                    case (rm)
                        3'd1:    inc = 1'b0;
                        3'd2:    inc = db & s;
                        3'd3:    inc = db & ~s;
                        3'd4:    inc = db;
                        default: inc = db & lsb;
                    endcase
                    v  = m + 64'(inc);
                    r  = (64'(s) << (fw + ew)) | v;
                    nx = db;
                    uf = db && (v < (64'd1 << fw));
                end
            end
        endcase
        if (!dbl) r = {32'hFFFF_FFFF, r[31:0]};
        res.data  = r;
        res.flags = {nv, 1'b0, 1'b0, uf, nx};
        res.tag   = t;
        return res;
    endfunction

    logic             hold_prev = 1'b0;
    logic [63:0]      prev_data;
    logic [4:0]       prev_flags;
    logic [TAG_W-1:0] prev_tag;

    always @(negedge RST_N) q.delete();

    always @(negedge CLK) begin
        exp_t e;
        if (RST_N) begin
            if (hold_prev && OUT_VALID) begin
                check("hold_data", OUT_DATA, prev_data);
                check("hold_flags", 64'(OUT_FLAGS), 64'(prev_flags));
                check("hold_tag", 64'(OUT_TAG), 64'(prev_tag));
            end
            if (IN_VALID && IN_READY)
                q.push_back(model(IN_DATA, IN_ISDOUBLE, IN_RM, IN_TAG));
            if (OUT_VALID && OUT_READY) begin
                n_out++;
                if (q.size() == 0) begin
                    check("spurious_out", 64'(OUT_VALID), 64'd0);
                end else begin
                    e = q.pop_front();
                    check("sb_data", OUT_DATA, e.data);
                    check("sb_flags", 64'(OUT_FLAGS), 64'(e.flags));
                    check("sb_tag", 64'(OUT_TAG), 64'(e.tag));
                end
            end
            if (FLUSH) q.delete();
            hold_prev  = OUT_VALID && !OUT_READY && !FLUSH;
            prev_data  = OUT_DATA;
            prev_flags = OUT_FLAGS;
            prev_tag   = OUT_TAG;
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic idle_inputs();
        IN_VALID    = 1'b0;
        FLUSH       = 1'b0;
        IN_DATA     = '0;
        IN_ISDOUBLE = 1'b0;
        IN_RM       = 3'd0;
        IN_TAG      = '0;
    endtask

    task automatic run_one(input string tag, input logic [65:0] d, input logic dbl,
                           input logic [2:0] rm, input logic [TAG_W-1:0] t,
                           input logic [63:0] exp_data, input logic [4:0] exp_flags);
        int lat;
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b1; IN_DATA = d; IN_ISDOUBLE = dbl; IN_RM = rm; IN_TAG = t;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        lat = 1;
        while (!OUT_VALID && lat < 20) begin
            @(posedge CLK); #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'd2);
        check({tag, "_data"}, OUT_DATA, exp_data);
        check({tag, "_flags"}, 64'(OUT_FLAGS), 64'(exp_flags));
        check({tag, "_tag"}, 64'(OUT_TAG), 64'(t));
        @(posedge CLK); #1;
    endtask

    task automatic drain(input string tag);
        int n;
        IN_VALID = 1'b0; FLUSH = 1'b0; OUT_READY = 1'b1;
        n = 0;
        while ((q.size() != 0 || OUT_VALID) && n < 30) begin
            @(posedge CLK); #1;
            n++;
        end
        check({tag, "_drained"}, 64'(q.size()), 64'd0);
    endtask

    function automatic logic [65:0] rand_in(logic dbl);
        logic [65:0] d;
        logic [1:0]  exc;
        d   = {$urandom(), $urandom(), 2'($urandom())};
        exc = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) != 0) exc = 2'b01;
        if (dbl) begin
            d[65:64] = exc;
            if ($urandom_range(0, 2) == 0) d[62:52] = '0;
            if ($urandom_range(0, 5) == 0) d[51:0] = '1;
        end else begin
            d[33:32] = exc;
            if ($urandom_range(0, 2) == 0) d[30:23] = '0;
            if ($urandom_range(0, 5) == 0) d[22:0] = '1;
        end
        return d;
    endfunction

    logic [65:0] items[4];

    initial begin
        int idx, n, acc, outs0;
        idle_inputs();
        OUT_READY = 1'b0;
        RST_N = 1'b0;
        #12;
        check("rst_out_valid", 64'(OUT_VALID), 64'd0);
        check("rst_out_data", OUT_DATA, 64'd0);
        check("rst_out_tag", 64'(OUT_TAG), 64'd0);
        check("rst_out_flags", 64'(OUT_FLAGS), 64'd0);
        check("rst_in_ready", 64'(IN_READY), 64'd0);
        #11 RST_N = 1'b1;
        @(posedge CLK); #1;

        // Directed cases with hand-computed results.
        run_one("dp_one", {2'b01, 1'b0, 11'h3FF, 52'd0}, 1'b1, 3'd0, 6'h15, 64'h3FF0_0000_0000_0000, 5'b00000);
        run_one("sp_ninf", 66'({2'b10, 1'b1, 31'd0}), 1'b0, 3'd0, 6'h01, 64'hFFFF_FFFF_FF80_0000, 5'b00000);
        run_one("sp_snan", 66'({2'b11, 1'b0, 8'hFF, 23'h000001}), 1'b0, 3'd0, 6'h02, 64'hFFFF_FFFF_7FC0_0000, 5'b10000);
        run_one("sp_qnan", 66'({2'b11, 1'b0, 8'hFF, 23'h400000}), 1'b0, 3'd0, 6'h03, 64'hFFFF_FFFF_7FC0_0000, 5'b00000);
        run_one("dp_sub_rne", {2'b01, 1'b0, 11'd0, 52'h1}, 1'b1, 3'd0, 6'h04, 64'h0008_0000_0000_0000, 5'b00011);
        run_one("dp_sub_rup", {2'b01, 1'b0, 11'd0, 52'h1}, 1'b1, 3'd3, 6'h05, 64'h0008_0000_0000_0001, 5'b00011);
        run_one("dp_sub_rtz", {2'b01, 1'b0, 11'd0, 52'h1}, 1'b1, 3'd1, 6'h06, 64'h0008_0000_0000_0000, 5'b00011);
        run_one("dp_sub_carry", {2'b01, 1'b0, 11'd0, {52{1'b1}}}, 1'b1, 3'd0, 6'h07, 64'h0010_0000_0000_0000, 5'b00001);
        run_one("sp_sub_rm7", 66'({2'b01, 1'b1, 8'd0, 23'h000003}), 1'b0, 3'd7, 6'h08, 64'hFFFF_FFFF_8040_0002, 5'b00011);

        // Backpressure: only two entries fit while the output is blocked.
        for (int i = 0; i < 4; i++) items[i] = rand_in(1'b1);
        OUT_READY = 1'b0;
        IN_ISDOUBLE = 1'b1; IN_RM = 3'd0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            IN_VALID = 1'b1; IN_DATA = items[idx]; IN_TAG = TAG_W'(6'h20 + idx);
            @(negedge CLK); acc = int'(IN_READY);
            @(posedge CLK); #1;
            if (acc != 0) idx++;
        end
        check("bp_accepts", 64'(idx), 64'd2);
        check("bp_in_ready", 64'(IN_READY), 64'd0);
        outs0 = n_out;
        OUT_READY = 1'b1;
        n = 0;
        while (idx < 4 && n < 20) begin
            IN_VALID = 1'b1; IN_DATA = items[idx]; IN_TAG = TAG_W'(6'h20 + idx);
            @(negedge CLK); acc = int'(IN_READY);
            @(posedge CLK); #1;
            if (acc != 0) idx++;
            n++;
        end
        drain("bp");
        check("bp_out_count", 64'(n_out - outs0), 64'd4);

        // Flush with both stages full and an input offered.
        OUT_READY = 1'b0;
        for (int i = 0; i < 2; i++) begin
            IN_VALID = 1'b1; IN_DATA = rand_in(1'b1); IN_TAG = TAG_W'(i);
            @(posedge CLK); #1;
        end
        IN_DATA = rand_in(1'b1); FLUSH = 1'b1;
        @(posedge CLK); #1;
        FLUSH = 1'b0; IN_VALID = 1'b0;
        check("flush_out_valid", 64'(OUT_VALID), 64'd0);
        run_one("post_flush", 66'({2'b00, 1'b1, 31'd0}), 1'b0, 3'd0, 6'h33, 64'hFFFF_FFFF_8000_0000, 5'b00000);

        // Asynchronous reset in the middle of a stream.
        OUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            IN_VALID = 1'b1; IN_DATA = rand_in(1'b1); IN_ISDOUBLE = 1'b1; IN_TAG = TAG_W'(i);
            @(posedge CLK); #1;
        end
        #1 RST_N = 1'b0;
        #1;
        check("arst_out_valid", 64'(OUT_VALID), 64'd0);
        check("arst_out_data", OUT_DATA, 64'd0);
        check("arst_in_ready", 64'(IN_READY), 64'd0);
        IN_VALID = 1'b0;
        @(posedge CLK); #2 RST_N = 1'b1;
        #1 check("post_rst_in_ready", 64'(IN_READY), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            check("post_rst_no_stale", 64'(OUT_VALID), 64'd0);
        end
        run_one("sp_zero", 66'd0, 1'b0, 3'd0, 6'h3A, 64'hFFFF_FFFF_0000_0000, 5'b00000);

        // Random traffic with random backpressure, rounding modes and rare flushes.
        for (int c = 0; c < 1500; c++) begin
            IN_VALID    = ($urandom_range(0, 3) != 0);
            IN_ISDOUBLE = 1'($urandom());
            IN_DATA     = rand_in(IN_ISDOUBLE);
            IN_RM       = 3'($urandom_range(0, 7));
            IN_TAG      = TAG_W'($urandom());
            OUT_READY   = ($urandom_range(0, 9) < 7);
            FLUSH       = ($urandom_range(0, 99) < 2);
            @(posedge CLK); #1;
        end
        drain("rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
